// File: rtl/calc_sequencer_if.sv
// Control/status bundle between calc_sequencer and its surroundings (pin wrapper, serdes, datapath).
// dbg_state mirrors the sequencer FSM state: LOAD=0, ARM=1, WAIT=2, DRAIN=3, CLEAR=4.
interface calc_sequencer_if;
    logic       in_valid;
    logic       abort;
    logic       dp_done;
    logic       load_en;
    logic       start_calc;
    logic       dp_start;
    logic       output_result;
    logic       out_valid;
    logic       serdes_clr_n;
    logic       busy;
    logic       err_timeout;
    logic [7:0] op_count;
    logic [2:0] dbg_state;

    modport master (
        output in_valid, abort, dp_done,
        input  load_en, start_calc, dp_start, output_result, out_valid,
               serdes_clr_n, busy, err_timeout, op_count, dbg_state
    );

    modport slave (
        input  in_valid, abort, dp_done,
        output load_en, start_calc, dp_start, output_result, out_valid,
               serdes_clr_n, busy, err_timeout, op_count, dbg_state
    );
endinterface

// File: rtl/calc_sequencer.sv
// Sequences one operation: count operand bytes, launch the datapath, wait with timeout,
// drain result bytes through the serdes, then clear it for the next operation.
module calc_sequencer #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 255
) (
    input logic            clk,
    input logic            reset,
    calc_sequencer_if.slave bus
);
    localparam int NBYTES = WIDTH / 8;
    localparam int BCW    = $clog2(2 * NBYTES + 1);
    localparam int WCW    = $clog2(TIMEOUT + 1);
    localparam int DCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [BCW-1:0] BYTES_LAST  = BCW'(2 * NBYTES);
    localparam logic [WCW-1:0] WAIT_LIMIT  = WCW'(TIMEOUT);
    localparam logic [DCW-1:0] DRAIN_FIRST = DCW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_CLEAR = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           err_q, err_d;
    logic [7:0]     ops_q, ops_d;
    logic           out_valid_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_LOAD;
            byte_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
            ops_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            err_q       <= err_d;
            ops_q       <= ops_d;
            out_valid_q <= (state_q == S_DRAIN);
        end
    end

    // abort is tested first in every working state so it beats the last byte, dp_done and timeout.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        err_d       = err_q;
        ops_d       = ops_q;
        case (state_q)
            S_LOAD: begin
                if (bus.abort) begin
                    state_d = S_CLEAR;
                end else if (bus.in_valid) begin
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_d == BYTES_LAST) state_d = S_ARM;
                end
            end
            S_ARM: begin
                state_d = bus.abort ? S_CLEAR : S_WAIT;
            end
            S_WAIT: begin
                if (bus.abort) begin
                    state_d = S_CLEAR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (bus.dp_done) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DRAIN_FIRST;
                    end else if (wait_cnt_d == WAIT_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.abort) begin
                    state_d = S_CLEAR;
                end else if (drain_cnt_q == '0) begin
                    ops_d   = ops_q + 8'd1;
                    state_d = S_CLEAR;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            S_CLEAR: begin
                byte_cnt_d  = '0;
                wait_cnt_d  = '0;
                drain_cnt_d = '0;
                state_d     = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign bus.load_en       = (state_q == S_LOAD) && bus.in_valid;
    assign bus.start_calc    = (state_q == S_ARM) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign bus.dp_start      = (state_q == S_ARM);
    assign bus.output_result = (state_q == S_DRAIN);
    assign bus.out_valid     = out_valid_q;
    assign bus.serdes_clr_n  = (state_q != S_CLEAR);
    assign bus.busy          = (state_q != S_LOAD);
    assign bus.err_timeout   = err_q;
    assign bus.op_count      = ops_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer at WIDTH=24, TIMEOUT=4 with hand-computed expectations.
module tb_calc_sequencer;
    localparam int WIDTH   = 24;
    localparam int TIMEOUT = 4;

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

    // Output vector order: load_en, start_calc, dp_start, output_result, out_valid, serdes_clr_n, busy
    localparam logic [6:0] V_IDLE = 7'b0000010;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    calc_sequencer_if bus();

    calc_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_ops = 8'd0;
    logic [6:0] exp_q[$];
    logic [6:0] obs_vec;

    assign obs_vec = {bus.load_en, bus.start_calc, bus.dp_start, bus.output_result,
                      bus.out_valid, bus.serdes_clr_n, bus.busy};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are then stable for sampling.
    task automatic cyc(input logic iv, input logic ab, input logic dd);
        @(negedge clk);
        bus.in_valid = iv;
        bus.abort    = ab;
        bus.dp_done  = dd;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_bytes(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Full operation with dp_done in the first WAIT cycle; ends on the CLEAR cycle.
    task automatic run_op();
        load_bytes(6);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle(4);
        exp_ops = exp_ops + 8'd1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
        bus.dp_done  = 1'b0;

        // reset
        reset = 1'b0;
        idle(3);
        check("rst_vec", obs_vec, V_IDLE);
        check("rst_state", bus.dbg_state, ST_LOAD);
        check("rst_err", bus.err_timeout, 1'b0);
        check("rst_ops", bus.op_count, 8'd0);
        reset = 1'b1;

        // nominal run, cycle-by-cycle trace
        for (int c = 0; c < 6; c++) exp_q.push_back(7'b1000010);
        exp_q.push_back(7'b0110011);
        exp_q.push_back(7'b0100011);
        exp_q.push_back(7'b0101011);
        exp_q.push_back(7'b0101111);
        exp_q.push_back(7'b0101111);
        exp_q.push_back(7'b0000101);
        exp_q.push_back(V_IDLE);
        exp_q.push_back(V_IDLE);
        for (int c = 0; c < 14; c++) begin
            cyc(c < 6, 1'b0, c == 7);
            check($sformatf("nom_c%0d", c), obs_vec, exp_q.pop_front());
            if (c == 12) check("nom_ops", bus.op_count, 8'd1);
        end
        exp_ops = 8'd1;
        check("nom_state", bus.dbg_state, ST_LOAD);

        // gapped input
        for (int i = 0; i < 11; i++) begin
            cyc((i % 2) == 0, 1'b0, 1'b0);
            check($sformatf("gap_le%0d", i), bus.load_en, (i % 2) == 0);
            check($sformatf("gap_st%0d", i), bus.dbg_state, ST_LOAD);
        end
        cyc(1'b0, 1'b0, 1'b0);
        check("gap_arm", bus.dbg_state, ST_ARM);
        check("gap_dps", bus.dp_start, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        idle(4);
        exp_ops = exp_ops + 8'd1;
        cyc(1'b0, 1'b0, 1'b0);
        check("gap_ops", bus.op_count, exp_ops);

        // timeout tie: dp_done on the 4th WAIT cycle wins
        load_bytes(6);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check($sformatf("tie_wait%0d", i), bus.dbg_state, ST_WAIT);
        end
        cyc(1'b0, 1'b0, 1'b1);
        check("tie_wait3", bus.dbg_state, ST_WAIT);
        cyc(1'b0, 1'b0, 1'b0);
        check("tie_drain", bus.dbg_state, ST_DRAIN);
        check("tie_or", bus.output_result, 1'b1);
        check("tie_err", bus.err_timeout, 1'b0);
        idle(3);
        exp_ops = exp_ops + 8'd1;
        cyc(1'b0, 1'b0, 1'b0);
        check("tie_ops", bus.op_count, exp_ops);

        // abort after 3rd byte
        load_bytes(3);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("ab3_state", bus.dbg_state, ST_CLEAR);
        check("ab3_clr", bus.serdes_clr_n, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("ab3_load", bus.dbg_state, ST_LOAD);
        check("ab3_ops", bus.op_count, exp_ops);

        // abort together with the final byte
        load_bytes(5);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("ab6_state", bus.dbg_state, ST_CLEAR);
        check("ab6_dps", bus.dp_start, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        // abort together with dp_done in WAIT
        load_bytes(6);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("abw_state", bus.dbg_state, ST_CLEAR);
        check("abw_or", bus.output_result, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("abw_load", bus.dbg_state, ST_LOAD);
        check("abw_ops", bus.op_count, exp_ops);
        check("abw_err", bus.err_timeout, 1'b0);

        // timeout
        load_bytes(6);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            check($sformatf("to_wait%0d", i), bus.dbg_state, ST_WAIT);
            check($sformatf("to_err%0d", i), bus.err_timeout, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        check("to_clear", bus.dbg_state, ST_CLEAR);
        check("to_err", bus.err_timeout, 1'b1);
        check("to_or", bus.output_result, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("to_load", bus.dbg_state, ST_LOAD);
        check("to_ops", bus.op_count, exp_ops);
        run_op();
        cyc(1'b0, 1'b0, 1'b0);
        check("to_next_ops", bus.op_count, exp_ops);
        check("to_sticky", bus.err_timeout, 1'b1);

        // reset during DRAIN
        load_bytes(6);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("rd_drain", bus.dbg_state, ST_DRAIN);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        check("rd_vec", obs_vec, V_IDLE);
        check("rd_state", bus.dbg_state, ST_LOAD);
        check("rd_ops", bus.op_count, 8'd0);
        check("rd_err", bus.err_timeout, 1'b0);
        reset   = 1'b1;
        exp_ops = 8'd0;

        // op_count wrap
        repeat (255) run_op();
        cyc(1'b0, 1'b0, 1'b0);
        check("wrap_255", bus.op_count, 8'd255);
        run_op();
        cyc(1'b0, 1'b0, 1'b0);
        check("wrap_0", bus.op_count, 8'd0);
        check("wrap_model", bus.op_count, exp_ops);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
